// File: rtl/i2c_wb_xfer_ctrl.sv
// Wishbone master that sequences the I2C core's register port to run complete
// single-byte register writes and reads. It returns read data or an error code.
module i2c_wb_xfer_ctrl #(
  parameter logic [15:0] PRESCALE   = 16'd99,
  parameter logic [15:0] POLL_LIMIT = 16'd4095
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  // Request / response
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       init_done,
  // Wishbone master toward the I2C core
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i
);

  localparam logic [2:0] AdrTxr = 3'd3;  // TXR on write, RXR on read
  localparam logic [2:0] AdrCr  = 3'd4;  // CR on write, SR on read

  localparam logic [1:0] ErrOk   = 2'b00;
  localparam logic [1:0] ErrNack = 2'b01;
  localparam logic [1:0] ErrAl   = 2'b10;
  localparam logic [1:0] ErrTout = 2'b11;

  typedef enum logic [3:0] {
    StInit, StIdle, StTxr, StCr, StPoll, StRxr, StSto, StStoPoll, StResp
  } state_e;

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [2:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic [1:0]  init_step_q, init_step_d;
  logic        init_done_q, init_done_d;
  logic [1:0]  phase_q, phase_d;
  logic        rd_q, rd_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [1:0]  xerr_q, xerr_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;

  logic [7:0] txr_val, cr_val, init_val;
  logic       last_phase, rd_phase, poll_expired;

  // Per-phase TXR/CR values; phase 3 only exists for reads (RD+NACK+STO).
  always_comb begin
    txr_val = 8'h00;
    cr_val  = 8'h68;
    unique case (phase_q)
      2'd0: begin txr_val = {dev_q, 1'b0}; cr_val = 8'h90; end
      2'd1: begin txr_val = reg_q;         cr_val = 8'h10; end
      2'd2: begin
        txr_val = rd_q ? {dev_q, 1'b1} : wdata_q;
        cr_val  = rd_q ? 8'h90 : 8'h50;
      end
      default: begin txr_val = 8'h00; cr_val = 8'h68; end
    endcase
  end

  always_comb begin
    unique case (init_step_q)
      2'd0:    init_val = PRESCALE[7:0];
      2'd1:    init_val = PRESCALE[15:8];
      default: init_val = 8'h80;
    endcase
  end

  assign last_phase   = rd_q ? (phase_q == 2'd3) : (phase_q == 2'd2);
  assign rd_phase     = rd_q && (phase_q == 2'd3);
  // Widened compare so the poll counter never needs to wrap.
  assign poll_expired = ({1'b0, poll_cnt_q} + 17'd1) >= {1'b0, POLL_LIMIT};

  // Sequencer: each access state launches one WB access when the bus is idle and
  // advances on ack; cyc drops for one cycle between consecutive accesses.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    init_step_d = init_step_q;
    init_done_d = init_done_q;
    phase_d     = phase_q;
    rd_d        = rd_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    poll_cnt_d  = poll_cnt_q;
    xerr_d      = xerr_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      StInit: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b1; adr_d = {1'b0, init_step_q}; dat_d = init_val;
        end else if (wbm_ack_i) begin
          cyc_d = 1'b0;
          if (init_step_q == 2'd2) begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end else begin
            init_step_d = init_step_q + 2'd1;
          end
        end
      end
      StIdle: begin
        if (req_valid && init_done_q) begin
          rd_d    = req_rd;
          dev_d   = req_dev;
          reg_d   = req_reg;
          wdata_d = req_wdata;
          phase_d = 2'd0;
          // Launch the first TXR write straight from the handshake.
          cyc_d   = 1'b1; we_d = 1'b1; adr_d = AdrTxr; dat_d = {req_dev, 1'b0};
          state_d = StTxr;
        end
      end
      StTxr: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b1; adr_d = AdrTxr; dat_d = txr_val;
        end else if (wbm_ack_i) begin
          cyc_d   = 1'b0;
          state_d = StCr;
        end
      end
      StCr: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b1; adr_d = AdrCr; dat_d = cr_val;
        end else if (wbm_ack_i) begin
          cyc_d      = 1'b0;
          poll_cnt_d = 16'd0;
          state_d    = StPoll;
        end
      end
      StPoll: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b0; adr_d = AdrCr; dat_d = 8'h00;
        end else if (wbm_ack_i) begin
          cyc_d      = 1'b0;
          poll_cnt_d = poll_cnt_q + 16'd1;
          if (wbm_dat_i[1]) begin
            if (poll_expired) begin
              xerr_d  = ErrTout;
              state_d = StSto;
            end
          end else if (wbm_dat_i[5]) begin
            // Arbitration lost: the core releases the bus itself, no STOP.
            rsp_err_d   = ErrAl;
            rsp_rdata_d = 8'h00;
            state_d     = StResp;
          end else if (wbm_dat_i[7] && !rd_phase) begin
            xerr_d  = ErrNack;
            state_d = StSto;
          end else if (last_phase) begin
            if (rd_q) begin
              state_d = StRxr;
            end else begin
              rsp_err_d   = ErrOk;
              rsp_rdata_d = 8'h00;
              state_d     = StResp;
            end
          end else begin
            phase_d = phase_q + 2'd1;
            // The read-byte phase has no TXR write.
            state_d = (rd_q && (phase_q == 2'd2)) ? StCr : StTxr;
          end
        end
      end
      StRxr: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b0; adr_d = AdrTxr; dat_d = 8'h00;
        end else if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_err_d   = ErrOk;
          rsp_rdata_d = wbm_dat_i;
          state_d     = StResp;
        end
      end
      StSto: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b1; adr_d = AdrCr; dat_d = 8'h40;
        end else if (wbm_ack_i) begin
          cyc_d      = 1'b0;
          poll_cnt_d = 16'd0;
          state_d    = StStoPoll;
        end
      end
      StStoPoll: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b0; adr_d = AdrCr; dat_d = 8'h00;
        end else if (wbm_ack_i) begin
          cyc_d      = 1'b0;
          poll_cnt_d = poll_cnt_q + 16'd1;
          // A second timeout abandons the STOP wait and reports the first error.
          if (!wbm_dat_i[6] || poll_expired) begin
            rsp_err_d   = xerr_q;
            rsp_rdata_d = 8'h00;
            state_d     = StResp;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StInit;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StInit;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 3'd0;
      dat_q       <= 8'h00;
      init_step_q <= 2'd0;
      init_done_q <= 1'b0;
      phase_q     <= 2'd0;
      rd_q        <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      poll_cnt_q  <= 16'd0;
      xerr_q      <= 2'b00;
      rsp_err_q   <= 2'b00;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      init_step_q <= init_step_d;
      init_done_q <= init_done_d;
      phase_q     <= phase_d;
      rd_q        <= rd_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      poll_cnt_q  <= poll_cnt_d;
      xerr_q      <= xerr_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == StIdle) && init_done_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_we_o  = we_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_cyc_o = cyc_q;

endmodule

// File: tb/tb_i2c_wb_xfer_ctrl.sv
// Bench for i2c_wb_xfer_ctrl: behavioural I2C-core register slave plus a
// transaction-level model of the expected register access trace and response.
module tb_i2c_wb_xfer_ctrl;

  localparam int Limit = 8;

  logic       clk = 1'b0;
  logic       wb_rst;
  logic       req_valid, req_ready, req_rd;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic       rsp_valid, init_done;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [2:0] wbm_adr;
  logic [7:0] wbm_dat_o;
  logic [7:0] wb_rdat = 8'h00;
  logic       wbm_we, wbm_stb, wbm_cyc;
  logic       wb_ack = 1'b0;

  always #5 clk = ~clk;

  i2c_wb_xfer_ctrl #(
    .PRESCALE  (16'd99),
    .POLL_LIMIT(16'd8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rd   (req_rd),
    .req_dev  (req_dev),
    .req_reg  (req_reg),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .init_done(init_done),
    .wbm_adr_o(wbm_adr),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wb_rdat),
    .wbm_we_o (wbm_we),
    .wbm_stb_o(wbm_stb),
    .wbm_cyc_o(wbm_cyc),
    .wbm_ack_i(wb_ack)
  );

  // Scenario knobs read by the slave: TIP-busy reads per phase, AL/RxACK flags at
  // phase completion, Busy reads after STOP, and the byte the slave returns.
  int         tip_n [4];
  bit         al_f [4];
  bit         rxk_f [4];
  int         sto_busy_n;
  logic [7:0] rx_byte;

  // Access log: {we, adr, write data (0 for reads)}
  logic [11:0] log_mem [0:8191];
  int          log_n = 0;

  int ph_idx = -1;
  int rem_tip = 0;
  int sto_rem = 0;
  int wait_n = 0;
  bit sto_mode = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] exp_q [$];
  logic [1:0]  exp_err;
  logic [7:0]  exp_rdata;

  int         rsp_cnt = 0;
  logic [1:0] cap_err = 2'b00;
  logic [7:0] cap_rdata = 8'h00;

  function automatic logic [7:0] sr_status(input int ph);
    if (ph < 0 || ph > 3) return 8'h40;
    return {rxk_f[ph], 1'b1, al_f[ph], 5'b00000};
  endfunction

  // I2C core register slave with random wait states.
  always @(posedge clk) begin
    if (wb_rst) begin
      wb_ack   <= 1'b0;
      ph_idx   <= -1;
      sto_mode <= 1'b0;
    end else begin
      if (req_valid && req_ready) ph_idx <= -1;
      if (wb_ack) begin
        wb_ack <= 1'b0;
        wait_n <= int'($urandom_range(0, 3));
      end else if (wbm_cyc && wbm_stb) begin
        if (wait_n != 0) begin
          wait_n <= wait_n - 1;
        end else begin
          wb_ack <= 1'b1;
          if (log_n < 8191) begin
            log_mem[log_n] <= {wbm_we, wbm_adr, wbm_we ? wbm_dat_o : 8'h00};
            log_n          <= log_n + 1;
          end
          if (wbm_we && wbm_adr == 3'd4) begin
            if (wbm_dat_o == 8'h40) begin
              sto_mode <= 1'b1;
              sto_rem  <= sto_busy_n;
            end else begin
              sto_mode <= 1'b0;
              ph_idx   <= ph_idx + 1;
              rem_tip  <= (ph_idx < 3) ? tip_n[ph_idx+1] : 0;
            end
          end
          if (!wbm_we && wbm_adr == 3'd4) begin
            if (sto_mode) begin
              if (sto_rem > 0) begin
                sto_rem <= sto_rem - 1;
                wb_rdat <= 8'h40;
              end else begin
                wb_rdat <= 8'h00;
              end
            end else if (rem_tip > 0) begin
              rem_tip <= rem_tip - 1;
              wb_rdat <= 8'h42;
            end else begin
              wb_rdat <= sr_status(ph_idx);
            end
          end
          if (!wbm_we && wbm_adr == 3'd3) wb_rdat <= rx_byte;
        end
      end
    end
  end

  // Response monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cnt   <= rsp_cnt + 1;
      cap_err   <= rsp_err;
      cap_rdata <= rsp_rdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_scn();
    for (int p = 0; p < 4; p++) begin
      tip_n[p] = 0; al_f[p] = 1'b0; rxk_f[p] = 1'b0;
    end
    sto_busy_n = 0;
    rx_byte    = 8'h00;
  endtask

  task automatic rand_scn();
    for (int p = 0; p < 4; p++) begin
      tip_n[p] = ($urandom_range(0, 15) == 0) ? Limit + int'($urandom_range(0, 4))
                                              : int'($urandom_range(0, 3));
      al_f[p]  = ($urandom_range(0, 15) == 0);
      rxk_f[p] = ($urandom_range(0, 7) == 0);
    end
    sto_busy_n = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 3));
    rx_byte    = 8'($urandom);
  endtask

  // Expected register trace and response of one transaction, from the
  // transaction rules: per phase TXR/CR writes, SR polls, error exits, STOP.
  task automatic build_exp(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd);
    logic [7:0] txr [4];
    logic [7:0] cr [4];
    bit sto, done;
    int np, m;
    txr[0] = {dev, 1'b0}; txr[1] = rg; txr[2] = rd ? {dev, 1'b1} : wd; txr[3] = 8'h00;
    cr[0]  = 8'h90; cr[1] = 8'h10; cr[2] = rd ? 8'h90 : 8'h50; cr[3] = 8'h68;
    exp_q.delete();
    exp_err = 2'b00; exp_rdata = 8'h00; sto = 1'b0; done = 1'b0;
    np = rd ? 4 : 3;
    for (int p = 0; p < np && !done; p++) begin
      if (!(rd && p == 3)) exp_q.push_back({1'b1, 3'd3, txr[p]});
      exp_q.push_back({1'b1, 3'd4, cr[p]});
      if (tip_n[p] >= Limit) begin
        repeat (Limit) exp_q.push_back({1'b0, 3'd4, 8'h00});
        exp_err = 2'b11; sto = 1'b1; done = 1'b1;
      end else begin
        repeat (tip_n[p] + 1) exp_q.push_back({1'b0, 3'd4, 8'h00});
        if (al_f[p]) begin
          exp_err = 2'b10; done = 1'b1;
        end else if (rxk_f[p] && !(rd && p == 3)) begin
          exp_err = 2'b01; sto = 1'b1; done = 1'b1;
        end
      end
    end
    if (!done && rd) begin
      exp_q.push_back({1'b0, 3'd3, 8'h00});
      exp_rdata = rx_byte;
    end
    if (sto) begin
      exp_q.push_back({1'b1, 3'd4, 8'h40});
      m = (sto_busy_n >= Limit) ? Limit : sto_busy_n + 1;
      repeat (m) exp_q.push_back({1'b0, 3'd4, 8'h00});
    end
  endtask

  task automatic issue_req(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input string tag);
    bit hs;
    req_valid = 1'b1; req_rd = rd; req_dev = dev; req_reg = rg; req_wdata = wd;
    hs = 1'b0;
    for (int i = 0; i < 200 && !hs; i++) begin
      if (req_ready) hs = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    req_rd    = 1'($urandom);
    req_dev   = 7'($urandom);
    req_reg   = 8'($urandom);
    req_wdata = 8'($urandom);
    check_eq({tag, ":accept"}, 32'(hs), 32'd1);
  endtask

  task automatic do_xfer(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input string tag);
    int base, cnt0, n;
    build_exp(rd, dev, rg, wd);
    @(negedge clk);
    base = log_n;
    cnt0 = rsp_cnt;
    issue_req(rd, dev, rg, wd, tag);
    for (int i = 0; i < 4000 && rsp_cnt == cnt0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq({tag, ":rsp_pulses"}, 32'(rsp_cnt - cnt0), 32'd1);
    check_eq({tag, ":err"}, 32'(cap_err), 32'(exp_err));
    check_eq({tag, ":rdata"}, 32'(cap_rdata), 32'(exp_rdata));
    check_eq({tag, ":err_hold"}, 32'(rsp_err), 32'(exp_err));
    n = log_n - base;
    check_eq({tag, ":trace_len"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      check_eq($sformatf("%s:trace[%0d]", tag, i), 32'(log_mem[base+i]), 32'(exp_q[i]));
      if (log_mem[base+i] !== exp_q[i]) break;
    end
  endtask

  task automatic check_init(input int base, input string tag);
    logic [11:0] exp_init [3];
    int n;
    exp_init[0] = {1'b1, 3'd0, 8'h63};
    exp_init[1] = {1'b1, 3'd1, 8'h00};
    exp_init[2] = {1'b1, 3'd2, 8'h80};
    for (int i = 0; i < 300 && !init_done; i++) @(negedge clk);
    check_eq({tag, ":init_done"}, 32'(init_done), 32'd1);
    check_eq({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    n = log_n - base;
    check_eq({tag, ":init_len"}, 32'(n), 32'd3);
    for (int i = 0; i < 3 && i < n; i++)
      check_eq($sformatf("%s:init[%0d]", tag, i), 32'(log_mem[base+i]), 32'(exp_init[i]));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cnt0;
    bit found;
    logic [11:0] cr10;
    wb_rst = 1'b1; req_valid = 1'b0; req_rd = 1'b0;
    req_dev = 7'd0; req_reg = 8'h00; req_wdata = 8'h00;
    clear_scn();
    repeat (3) @(negedge clk);
    check_eq("reset_outs",
             32'({init_done, req_ready, rsp_valid, wbm_cyc, wbm_stb, rsp_err, rsp_rdata}), 32'd0);
    base = log_n;
    wb_rst = 1'b0;
    check_init(base, "por");

    clear_scn(); tip_n = '{1, 0, 2, 0};
    do_xfer(1'b0, 7'h50, 8'h12, 8'hA5, "wr");
    clear_scn(); rx_byte = 8'h3C; tip_n = '{0, 3, 1, 2};
    do_xfer(1'b1, 7'h50, 8'h12, 8'h00, "rd");
    clear_scn(); rxk_f[0] = 1'b1; sto_busy_n = 2;
    do_xfer(1'b0, 7'h50, 8'h12, 8'hA5, "nack");
    clear_scn(); al_f[1] = 1'b1;
    do_xfer(1'b1, 7'h21, 8'h34, 8'h00, "al");
    clear_scn(); tip_n[0] = 40;
    do_xfer(1'b0, 7'h11, 8'h22, 8'h33, "tout");
    clear_scn(); tip_n[2] = Limit - 1;
    do_xfer(1'b0, 7'h11, 8'h22, 8'h33, "tip_edge");
    clear_scn(); tip_n[1] = Limit;
    do_xfer(1'b0, 7'h11, 8'h22, 8'h33, "tip_lim");
    clear_scn(); rxk_f[3] = 1'b1; rx_byte = 8'hC3;
    do_xfer(1'b1, 7'h7F, 8'hFF, 8'h00, "rd_nack_ok");
    clear_scn(); rxk_f[2] = 1'b1; sto_busy_n = 20;
    do_xfer(1'b0, 7'h05, 8'h06, 8'h07, "sto_tout");

    for (int t = 0; t < 40; t++) begin
      rand_scn();
      do_xfer(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), "rnd");
    end

    // Reset in the middle of a read, after the register-index CR write.
    clear_scn(); tip_n = '{2, 2, 2, 2}; rx_byte = 8'h99;
    cr10 = {1'b1, 3'd4, 8'h10};
    @(negedge clk);
    base = log_n;
    cnt0 = rsp_cnt;
    issue_req(1'b1, 7'h50, 8'h12, 8'h00, "mid");
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      for (int k = base; k < log_n; k++) if (log_mem[k] == cr10) found = 1'b1;
      if (!found) @(negedge clk);
    end
    check_eq("mid:cr10_seen", 32'(found), 32'd1);
    wb_rst = 1'b1;
    @(negedge clk);
    check_eq("mid:cyc_drop", 32'({wbm_cyc, wbm_stb}), 32'd0);
    check_eq("mid:init_clr", 32'(init_done), 32'd0);
    @(negedge clk);
    base = log_n;
    wb_rst = 1'b0;
    check_init(base, "mid");
    check_eq("mid:no_rsp", 32'(rsp_cnt - cnt0), 32'd0);
    clear_scn();
    do_xfer(1'b0, 7'h50, 8'h12, 8'hA5, "post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
